mcpu_core: RTL and testbench

Multi-cycle, parametrised successor to the team's single-cycle MIPS-subset datapath. It fetches, decodes, executes and writes back one instruction at a time through a five-state FSM. It talks to a single unified instruction/data memory over a req/ready handshake, so wait-state memories can be attached. It adds a configurable reset PC, a configurable register count, a memory-timeout halt, and optional shift instructions.

---
 rtl/mcpu_pkg.sv | 55 +++++
 rtl/mcpu_alu.sv | 32 +++
 rtl/mcpu_core.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mcpu_core.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core:
// opcode/funct codes, FSM states, ALU operations and halt causes.
package mcpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_LUI
   } alu_op_e;

   localparam logic [1:0] HC_NONE    = 2'b00;
   localparam logic [1:0] HC_ILLEGAL = 2'b01;
   localparam logic [1:0] HC_TIMEOUT = 2'b10;

   // A register field is usable only if no bit above the
   // configured index width is set.
   function automatic logic reg_ok(input logic [4:0] f,
                                   input int unsigned aw);
      return (f >> aw) == 5'd0;
   endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational 32-bit ALU for mcpu_core.
// Ports: a_i, b_i operands; shamt_i shift amount; op_i operation;
// result_o result; zero_o high when result is zero.
module mcpu_alu
   import mcpu_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [4:0]  shamt_i,
   input  alu_op_e     op_i,
   output logic [31:0] result_o,
   output logic        zero_o
);

   always_comb begin
      result_o = 32'h0;
      unique case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_SLL: result_o = b_i << shamt_i;
         ALU_SRL: result_o = b_i >> shamt_i;
         ALU_SRA: result_o = $signed(b_i) >>> shamt_i;
         ALU_LUI: result_o = {b_i[15:0], 16'h0};
         default: result_o = 32'h0;
      endcase
   end

   assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle MIPS-subset core with unified req/ready memory port.
// Ports: clk, pcrst (sync, active-low); mem_req/we/addr/wdata out,
// mem_rdata/ready in; pc_o debug PC; halt, halt_cause status.
// Build option: define MCPU_SHIFT_EN to enable sll/srl/sra.
module mcpu_core
   import mcpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = 32'h0000_0000,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        pcrst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_o,
   output logic        halt,
   output logic [1:0]  halt_cause
);

   localparam int NREG = 1 << REG_ADDR_W;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] res_q, res_d;
   logic [31:0] tmo_q, tmo_d;
   logic [1:0]  cause_q, cause_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] regs_q [NREG];

   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm16;
   logic [25:0] addr26;

   assign op     = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign sa     = ir_q[10:6];
   assign funct  = ir_q[5:0];
   assign imm16  = ir_q[15:0];
   assign addr26 = ir_q[25:0];

   alu_op_e     alu_op;
   logic        use_imm, sext, legal, fields_ok;
   logic        wr_rd, is_lw, is_sw, is_beq, is_bne, is_j;
   logic [31:0] imm_ext;
   logic [31:0] alu_res;
   logic        alu_zero;

   // Decode is purely a function of IR, which stays put from
   // DECODE until the instruction retires.
   always_comb begin
      alu_op    = ALU_ADD;
      use_imm   = 1'b0;
      sext      = 1'b1;
      legal     = 1'b0;
      wr_rd     = 1'b0;
      is_lw     = 1'b0;
      is_sw     = 1'b0;
      is_beq    = 1'b0;
      is_bne    = 1'b0;
      is_j      = 1'b0;
      fields_ok = reg_ok(rs, REG_ADDR_W)
                  && reg_ok(rt, REG_ADDR_W);
      case (op)
         OP_RTYPE: begin
            wr_rd     = 1'b1;
            fields_ok = fields_ok && reg_ok(rd, REG_ADDR_W);
            case (funct)
               FN_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
               FN_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
               FN_AND: begin alu_op = ALU_AND; legal = 1'b1; end
               FN_OR:  begin alu_op = ALU_OR;  legal = 1'b1; end
`ifdef MCPU_SHIFT_EN
               FN_SLL: begin alu_op = ALU_SLL; legal = 1'b1; end
               FN_SRL: begin alu_op = ALU_SRL; legal = 1'b1; end
               FN_SRA: begin alu_op = ALU_SRA; legal = 1'b1; end
`else
               // Only the all-zero word (nop) survives here.
               FN_SLL: begin
                  alu_op = ALU_SLL;
                  legal  = (ir_q == 32'h0);
               end
`endif
               default: legal = 1'b0;
            endcase
         end
         OP_ADDI: begin
            use_imm = 1'b1;
            legal   = 1'b1;
         end
         OP_ANDI: begin
            alu_op  = ALU_AND;
            use_imm = 1'b1;
            sext    = 1'b0;
            legal   = 1'b1;
         end
         OP_ORI: begin
            alu_op  = ALU_OR;
            use_imm = 1'b1;
            sext    = 1'b0;
            legal   = 1'b1;
         end
         OP_LUI: begin
            alu_op    = ALU_LUI;
            use_imm   = 1'b1;
            legal     = 1'b1;
            fields_ok = reg_ok(rt, REG_ADDR_W);
         end
         OP_LW: begin
            use_imm = 1'b1;
            is_lw   = 1'b1;
            legal   = 1'b1;
         end
         OP_SW: begin
            use_imm = 1'b1;
            is_sw   = 1'b1;
            legal   = 1'b1;
         end
         OP_BEQ: begin
            alu_op = ALU_SUB;
            is_beq = 1'b1;
            legal  = 1'b1;
         end
         OP_BNE: begin
            alu_op = ALU_SUB;
            is_bne = 1'b1;
            legal  = 1'b1;
         end
         OP_J: begin
            is_j      = 1'b1;
            legal     = 1'b1;
            fields_ok = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign imm_ext = sext ? {{16{imm16[15]}}, imm16}
                         : {16'h0, imm16};

   mcpu_alu u_alu (
      .a_i      (a_q),
      .b_i      (use_imm ? imm_ext : b_q),
      .shamt_i  (sa),
      .op_i     (alu_op),
      .result_o (alu_res),
      .zero_o   (alu_zero)
   );

   assign rf_waddr = wr_rd ? rd[REG_ADDR_W-1:0]
                           : rt[REG_ADDR_W-1:0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cause_d = cause_q;
      rf_we   = 1'b0;
      // Counts consecutive unanswered request cycles.
      tmo_d   = (mem_req_q && !mem_ready) ? tmo_q + 32'd1 : 32'd0;

      unique case (state_q)
         ST_FETCH: begin
            if (mem_req_q && mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 32'd4;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            a_d = regs_q[rs[REG_ADDR_W-1:0]];
            b_d = regs_q[rt[REG_ADDR_W-1:0]];
            if (legal && fields_ok) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_HALT;
               cause_d = HC_ILLEGAL;
            end
         end
         ST_EXEC: begin
            res_d   = alu_res;
            state_d = ST_WB;
            if (is_lw || is_sw) begin
               state_d = ST_MEM;
            end else if (is_beq || is_bne) begin
               // PC already points past the branch.
               if (alu_zero == is_beq)
                  pc_d = pc_q + {imm_ext[29:0], 2'b00};
               state_d = ST_FETCH;
            end else if (is_j) begin
               pc_d    = {pc_q[31:28], addr26, 2'b00};
               state_d = ST_FETCH;
            end
         end
         ST_MEM: begin
            if (mem_req_q && mem_ready) begin
               if (is_lw) begin
                  res_d   = mem_rdata;
                  state_d = ST_WB;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_WB: begin
            rf_we   = (rf_waddr != '0);
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase

      if (mem_req_q && !mem_ready && tmo_d >= TIMEOUT) begin
         state_d = ST_HALT;
         cause_d = HC_TIMEOUT;
      end
   end

   // Memory outputs are registered from the next state, so a
   // request is presented in the first cycle of FETCH/MEM and
   // held unchanged while waiting.
   always_comb begin
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (state_d == ST_FETCH) begin
         mem_req_d   = 1'b1;
         mem_addr_d  = {pc_d[31:2], 2'b00};
         mem_wdata_d = 32'h0;
      end else if (state_d == ST_MEM) begin
         mem_req_d   = 1'b1;
         mem_we_d    = is_sw;
         mem_addr_d  = {res_d[31:2], 2'b00};
         mem_wdata_d = is_sw ? b_q : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (!pcrst) begin
         state_q     <= ST_FETCH;
         pc_q        <= PC_RESET;
         ir_q        <= 32'h0;
         a_q         <= 32'h0;
         b_q         <= 32'h0;
         res_q       <= 32'h0;
         tmo_q       <= 32'h0;
         cause_q     <= HC_NONE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         for (int i = 0; i < NREG; i++)
            regs_q[i] <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         tmo_q       <= tmo_d;
         cause_q     <= cause_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if (rf_we)
            regs_q[rf_waddr] <= res_q;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign pc_o       = pc_q;
   assign halt       = (state_q == ST_HALT);
   assign halt_cause = cause_q;

endmodule

// File: tb/tb_mcpu_core.sv
// Directed testbench for mcpu_core: wait-state memory model,
// per-scenario tasks with hand-computed expectations.
module tb_mcpu_core;

   logic        clk = 1'b0;
   logic        pcrst = 1'b0;
   logic        mem_req, mem_we, mem_ready, halt;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
   logic [1:0]  halt_cause;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mcpu_core #(
      .PC_RESET   (32'h0000_0100),
      .REG_ADDR_W (5),
      .TIMEOUT    (10)
   ) dut (
      .clk        (clk),
      .pcrst      (pcrst),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .pc_o       (pc_o),
      .halt       (halt),
      .halt_cause (halt_cause)
   );

   // Program words live at 0x100.., data words at 0x00..0xFC.
   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   int          wait_n = 0;
   bit          ready_off = 1'b0;
   int          wcnt = 0;

   assign mem_ready = mem_req && !ready_off && (wcnt >= wait_n);
   assign mem_rdata = mem_addr[8] ? imem[mem_addr[7:2]]
                                  : dmem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_req && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_req && mem_ready && mem_we && !mem_addr[8])
         dmem[mem_addr[7:2]] <= mem_wdata;
   end

   localparam logic [31:0] LOOP = 32'h1000_FFFF;

   function automatic logic [31:0] enc_i(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sa, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   task automatic load_prog(input logic [31:0] w0,
      input logic [31:0] w1, input logic [31:0] w2);
      for (int i = 0; i < 64; i++) imem[i] = LOOP;
      imem[0] = w0;
      imem[1] = w1;
      imem[2] = w2;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at the negedge of the first post-reset cycle.
   task automatic do_reset();
      @(negedge clk);
      pcrst = 1'b0;
      step(2);
      pcrst = 1'b1;
      step(1);
   endtask

   task automatic test_reset();
      load_prog(LOOP, LOOP, LOOP);
      wait_n = 0;
      @(negedge clk);
      pcrst = 1'b0;
      step(2);
      n_chk++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_req: got %0b want 0", mem_req);
      end
      n_chk++;
      if (mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_we: got %0b want 0", mem_we);
      end
      n_chk++;
      if (mem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_addr: got %h want 0", mem_addr);
      end
      n_chk++;
      if (mem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_wdata: got %h want 0", mem_wdata);
      end
      n_chk++;
      if (pc_o !== 32'h100) begin
         n_fail++;
         $display("FAIL rst_pc: got %h want 100", pc_o);
      end
      n_chk++;
      if (halt !== 1'b0 || halt_cause !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_halt: got %0b/%b want 0/00",
                  halt, halt_cause);
      end
      pcrst = 1'b1;
      step(1);
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL first_fetch: got req %0b addr %h want 1 100",
                  mem_req, mem_addr);
      end
   endtask

   task automatic test_arith();
      load_prog(enc_i(6'h08, 5'd0, 5'd1, 16'd5),
                enc_i(6'h08, 5'd0, 5'd2, 16'd7),
                enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
      wait_n = 0;
      do_reset();
      step(11);
      n_chk++;
      if (dut.regs_q[3] !== 32'd0) begin
         n_fail++;
         $display("FAIL add_early: got %h want 0", dut.regs_q[3]);
      end
      step(1);
      n_chk++;
      if (dut.regs_q[3] !== 32'd12) begin
         n_fail++;
         $display("FAIL add_r3: got %h want c", dut.regs_q[3]);
      end
      n_chk++;
      if (dut.regs_q[1] !== 32'd5 || dut.regs_q[2] !== 32'd7) begin
         n_fail++;
         $display("FAIL addi_r1r2: got %h %h want 5 7",
                  dut.regs_q[1], dut.regs_q[2]);
      end
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10C) begin
         n_fail++;
         $display("FAIL next_fetch: got %0b %h want 1 10c",
                  mem_req, mem_addr);
      end
   endtask

   task automatic test_mem_wait();
      logic        p_pend;
      logic        p_req, p_we;
      logic [31:0] p_addr, p_wdata, st_addr, st_data;
      bit          st_seen;
      load_prog(enc_i(6'h08, 5'd0, 5'd3, 16'd12),
                enc_i(6'h2B, 5'd0, 5'd3, 16'h0040),
                enc_i(6'h23, 5'd0, 5'd4, 16'h0040));
      wait_n = 3;
      do_reset();
      p_pend = 1'b0;
      p_req = 1'b0;
      p_we = 1'b0;
      p_addr = '0;
      p_wdata = '0;
      st_seen = 1'b0;
      st_addr = '0;
      st_data = '0;
      for (int c = 0; c < 28; c++) begin
         if (p_pend) begin
            n_chk++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !==
                {p_req, p_we, p_addr, p_wdata}) begin
               n_fail++;
               $display("FAIL req_stable: cyc %0d got %0b %0b %h %h want %0b %0b %h %h",
                        c, mem_req, mem_we, mem_addr, mem_wdata,
                        p_req, p_we, p_addr, p_wdata);
            end
         end
         if (c == 27) begin
            n_chk++;
            if (dut.regs_q[4] !== 32'd0) begin
               n_fail++;
               $display("FAIL lw_early: got %h want 0", dut.regs_q[4]);
            end
         end
         if (mem_req && mem_we && mem_ready) begin
            st_seen = 1'b1;
            st_addr = mem_addr;
            st_data = mem_wdata;
         end
         p_pend = mem_req && !mem_ready;
         p_req = mem_req;
         p_we = mem_we;
         p_addr = mem_addr;
         p_wdata = mem_wdata;
         step(1);
      end
      n_chk++;
      if (!st_seen || st_addr !== 32'h40 || st_data !== 32'd12) begin
         n_fail++;
         $display("FAIL sw_req: seen %0b addr %h data %h want 1 40 c",
                  st_seen, st_addr, st_data);
      end
      n_chk++;
      if (dmem[16] !== 32'd12) begin
         n_fail++;
         $display("FAIL sw_mem: got %h want c", dmem[16]);
      end
      n_chk++;
      if (dut.regs_q[4] !== 32'd12) begin
         n_fail++;
         $display("FAIL lw_r4: got %h want c", dut.regs_q[4]);
      end
   endtask

   task automatic test_branch();
      load_prog(enc_i(6'h08, 5'd0, 5'd1, 16'd1),
                enc_i(6'h05, 5'd1, 5'd1, 16'd5),
                enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
      wait_n = 0;
      do_reset();
      step(4);
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
         n_fail++;
         $display("FAIL bne_fetch: got %0b %h want 1 104",
                  mem_req, mem_addr);
      end
      step(3);
      n_chk++;
      if (mem_addr !== 32'h108) begin
         n_fail++;
         $display("FAIL bne_fall: got %h want 108", mem_addr);
      end
      step(1);
      n_chk++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL dec_noreq: got %0b want 0", mem_req);
      end
      for (int k = 0; k < 2; k++) begin
         step(k == 0 ? 2 : 3);
         n_chk++;
         if (mem_addr !== 32'h108 || pc_o !== 32'h108) begin
            n_fail++;
            $display("FAIL beq_loop%0d: got %h pc %h want 108",
                     k, mem_addr, pc_o);
         end
      end
   endtask

   task automatic test_shift();
      load_prog(32'h0,
                enc_i(6'h0F, 5'd0, 5'd1, 16'h8000),
                enc_r(5'd0, 5'd1, 5'd2, 5'd4, 6'h03));
      wait_n = 0;
      do_reset();
      step(12);
      n_chk++;
      if (dut.regs_q[1] !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL lui_r1: got %h want 80000000", dut.regs_q[1]);
      end
`ifdef MCPU_SHIFT_EN
      n_chk++;
      if (dut.regs_q[2] !== 32'hF800_0000 || halt !== 1'b0) begin
         n_fail++;
         $display("FAIL sra_r2: got %h halt %0b want f8000000 0",
                  dut.regs_q[2], halt);
      end
`else
      n_chk++;
      if (halt !== 1'b1 || halt_cause !== 2'b01) begin
         n_fail++;
         $display("FAIL sra_illegal: got %0b/%b want 1/01",
                  halt, halt_cause);
      end
      n_chk++;
      if (dut.regs_q[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL sra_nowr: got %h want 0", dut.regs_q[2]);
      end
`endif
   endtask

   task automatic test_reset_mid();
      bit found;
      load_prog(enc_i(6'h08, 5'd0, 5'd0, 16'd9),
                enc_i(6'h23, 5'd0, 5'd5, 16'h0040),
                LOOP);
      wait_n = 3;
      do_reset();
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (mem_req && !mem_we && mem_addr == 32'h40 && !mem_ready)
            found = 1'b1;
         else
            step(1);
      end
      n_chk++;
      if (!found) begin
         n_fail++;
         $display("FAIL lw_wait_seen: got none want lw request in 40 cycles");
      end
      n_chk++;
      if (dut.regs_q[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL r0_zero: got %h want 0", dut.regs_q[0]);
      end
      pcrst = 1'b0;
      step(1);
      n_chk++;
      if (mem_req !== 1'b0 || pc_o !== 32'h100) begin
         n_fail++;
         $display("FAIL mid_rst: got req %0b pc %h want 0 100",
                  mem_req, pc_o);
      end
      n_chk++;
      if (dut.regs_q[5] !== 32'h0) begin
         n_fail++;
         $display("FAIL lw_abandon: got %h want 0", dut.regs_q[5]);
      end
      pcrst = 1'b1;
      step(1);
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL restart: got %0b %h want 1 100",
                  mem_req, mem_addr);
      end
   endtask

   task automatic test_timeout();
      load_prog(LOOP, LOOP, LOOP);
      wait_n = 0;
      ready_off = 1'b1;
      do_reset();
      step(9);
      n_chk++;
      if (halt !== 1'b0 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_early: got halt %0b req %0b want 0 1",
                  halt, mem_req);
      end
      step(1);
      n_chk++;
      if (halt !== 1'b1 || halt_cause !== 2'b10) begin
         n_fail++;
         $display("FAIL tmo_halt: got %0b/%b want 1/10",
                  halt, halt_cause);
      end
      n_chk++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_drop: got %0b want 0", mem_req);
      end
      ready_off = 1'b0;
      step(5);
      n_chk++;
      if (mem_req !== 1'b0 || halt !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_sticky: got req %0b halt %0b want 0 1",
                  mem_req, halt);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) imem[i] = LOOP;
      test_reset();
      test_arith();
      test_mem_wait();
      test_branch();
      test_shift();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish by 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
